// File: rtl/rssb_ctrl.sv
// rssb_ctrl: fetch/decode/read/exec sequencer for the RSSB one-instruction core
module rssb_ctrl #(
  parameter int DW = 8,
  parameter logic [DW-1:0] PC_INIT = 8'h00,
  parameter logic [DW-1:0] HALT_OP = 8'hFF,
  parameter logic [DW-1:0] OUT_ADDR = 8'hFE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [DW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          busy,
  output logic          halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, EXEC, HALT} state_t;
  state_t state, state_n;
  logic [DW-1:0] ir, diff;
  logic borrow;
  assign diff = mem_rdata - acc;
  assign borrow = mem_rdata < acc;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = run ? FETCH : IDLE;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = mem_rdata == HALT_OP ? HALT : READ;
      READ:    state_n = EXEC;
      EXEC:    state_n = run ? FETCH : IDLE;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end
  // strobes are gated by rst so an in-flight write is dropped the moment reset rises
  assign mem_rd = ~rst & (state == FETCH | state == READ);
  assign mem_wr = ~rst & (state == EXEC);
  assign mem_addr = (mem_rd & state == FETCH) ? pc : (mem_rd | mem_wr) ? ir : '0;
  assign mem_wdata = mem_wr ? diff : '0;
  assign out_valid = mem_wr & (ir == OUT_ADDR);
  assign busy = (state != IDLE) & (state != HALT);
  assign halted = state == HALT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= PC_INIT;
      acc <= '0;
      ir <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE) ir <= mem_rdata;
      if (state == EXEC) begin
        acc <= diff;
        pc <= pc + (borrow ? DW'(2) : DW'(1));
        if (out_valid) out_data <= diff;
      end
    end
  end
endmodule

// File: tb/tb_rssb_ctrl.sv
// tb_rssb_ctrl: scoreboarded directed test of rssb_ctrl against a behavioural RAM
module tb_rssb_ctrl;
  logic clk = 0, rst, run;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, out_data, pc, acc;
  logic mem_rd, mem_wr, out_valid, busy, halted;
  logic poke_en;
  logic [7:0] poke_addr, poke_data;
  logic [7:0] mem [256];
  typedef struct {logic [7:0] a; logic [7:0] d; logic o;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] rd_log[$];
  int checks = 0, errors = 0;

  rssb_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .pc(pc), .acc(acc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every write is popped against the scoreboard; quiet cycles must leave the bus at zero
  always @(negedge clk) begin
    if (mem_wr) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
        chk("wr_out_valid", out_valid, e.o);
      end
      chk("rd_wr_excl", mem_rd, 0);
    end else begin
      chk("out_valid_quiet", out_valid, 0);
      if (!mem_rd) chk("bus_quiet", {mem_addr, mem_wdata}, 0);
    end
    if (mem_rd) rd_log.push_back(mem_addr);
    if (!busy) chk("no_strobe_idle", {mem_rd, mem_wr}, 0);
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en = 1;
    @(negedge clk);
    poke_en = 0;
  endtask

  // starts at a negedge in IDLE; drops run during READ of the last instruction
  task automatic step(input int n);
    run = 1;
    repeat (4 * n - 1) @(negedge clk);
    run = 0;
    @(negedge clk);
    chk("exec_on_cycle_4n", mem_wr, 1);
    @(negedge clk);
    chk("idle_after_run_drop", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    run = 0;
    poke_en = 0;
    poke_addr = 0;
    poke_data = 0;
    repeat (10) @(negedge clk);
    chk("rst_pc", pc, 8'h00);
    chk("rst_acc", acc, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", {mem_rd, mem_wr, out_valid}, 0);
    chk("rst_out_data", out_data, 8'h00);
    poke(8'h00, 8'h10);
    poke(8'h10, 8'h05);
    poke(8'h01, 8'h11);
    poke(8'h11, 8'h03);
    rst = 0;
    @(negedge clk);
    chk("idle_without_run", busy, 0);

    rd_log.delete();
    q.push_back('{8'h10, 8'h05, 1'b0});
    step(1);
    chk("t2_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("t2_rd0", rd_log[0], 8'h00);
      chk("t2_rd1", rd_log[1], 8'h10);
    end
    chk("t2_acc", acc, 8'h05);
    chk("t2_pc", pc, 8'h01);

    q.push_back('{8'h11, 8'hFE, 1'b0});
    step(1);
    chk("t3_acc", acc, 8'hFE);
    chk("t3_pc", pc, 8'h03);

    // walk pc up to FF with no-op subtracts on scratch word 02, then set acc=02 via a borrow skip
    poke(8'h02, 8'hFE);
    for (int a = 3; a <= 8'hFB; a++) poke(8'(a), 8'h02);
    poke(8'hFC, 8'h00);
    poke(8'h00, 8'hFE);
    poke(8'hFD, 8'h01);
    poke(8'h01, 8'h00);
    poke(8'hFF, 8'hFE);
    poke(8'hFE, 8'h09);
    for (int i = 0; i < 249; i++) q.push_back('{8'h02, 8'h00, 1'b0});
    q.push_back('{8'h00, 8'hFE, 1'b0});
    q.push_back('{8'h01, 8'h02, 1'b0});
    q.push_back('{8'hFE, 8'h07, 1'b1});
    step(252);
    chk("t4_out_data", out_data, 8'h07);
    chk("t4_mem_fe", mem[8'hFE], 8'h07);
    chk("t4_pc_wrap", pc, 8'h00);
    chk("t4_acc", acc, 8'h07);

    poke(8'h00, 8'hFF);
    run = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_decode_busy", busy, 1);
    @(negedge clk);
    chk("t5_halted", halted, 1);
    chk("t5_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      @(negedge clk);
      chk("t5_stays_halted", halted, 1);
    end
    chk("t5_pc", pc, 8'h00);
    chk("t5_acc", acc, 8'h07);
    #1 rst = 1;
    run = 0;
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("t5_rst_halted", halted, 0);
    chk("t5_rst_pc", pc, 8'h00);

    poke(8'h00, 8'h30);
    poke(8'h30, 8'h04);
    q.push_back('{8'h30, 8'h04, 1'b0});
    step(1);
    chk("t6_pc", pc, 8'h01);
    chk("t6_acc", acc, 8'h04);
    repeat (3) @(negedge clk);
    chk("t6_idle_pc_hold", pc, 8'h01);

    poke(8'h01, 8'h31);
    poke(8'h31, 8'h01);
    q.push_back('{8'h31, 8'hFD, 1'b0});
    run = 1;
    repeat (4) @(negedge clk);
    chk("t6b_in_exec", mem_wr, 1);
    #1 rst = 1;
    run = 0;
    #1;
    chk("t6b_wr_dropped", mem_wr, 0);
    chk("t6b_pc", pc, 8'h00);
    chk("t6b_acc", acc, 8'h00);
    chk("t6b_out_data", out_data, 8'h00);
    chk("t6b_busy", busy, 0);
    @(negedge clk);
    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk("t6b_mem_31_kept", mem[8'h31], 8'h01);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
